// File: rtl/pc_source_unit_if.sv
// Update-request bus from the control unit into the PC source unit: valid/ready
// handshake carrying the source selector and the flattened candidate PCs.
interface pc_source_unit_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3
);
    logic                     upd_valid;
    logic                     upd_ready;
    logic [SEL_W-1:0]         sel;
    logic [NUM_SRC*WIDTH-1:0] data_in;

    modport master (
        output upd_valid,
        output sel,
        output data_in,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  sel,
        input  data_in,
        output upd_ready
    );
endinterface

// File: rtl/pc_source_unit.sv
// Purpose: selects the next PC from NUM_SRC sources, holds it, flushes after redirects, flags bad selectors.
// Latency: 1 cycle from accepted update to pc_out/pc_prev/sel_err/redirect_count.
// Backpressure: upd_ready low (state-only) for FLUSH_CYCLES after a redirect; optional counter via PC_SOURCE_REDIRECT_COUNT_EN.
module pc_source_unit #(
    parameter int               WIDTH        = 32,
    parameter int               NUM_SRC      = 5,
    parameter int               SEL_W        = 3,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    pc_source_unit_if.slave    upd,
    output logic [WIDTH-1:0]   pc_out,
    output logic [WIDTH-1:0]   pc_prev,
    output logic               pc_valid,
    output logic               sel_err,
    output logic [31:0]        redirect_count
);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0]     FLUSH_LD  = 4'(FLUSH_CYCLES);
    localparam bit             HAS_FLUSH = (FLUSH_CYCLES > 0);
    localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W+1)'(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("pc_source_unit: NUM_SRC must be 2..16");
    end
    if ((2 ** SEL_W) < NUM_SRC) begin : g_bad_sel_w
        $error("pc_source_unit: SEL_W too narrow for NUM_SRC");
    end
    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15) begin : g_bad_flush
        $error("pc_source_unit: FLUSH_CYCLES must be 0..15");
    end

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_q, prev_q;
    logic             err_q;
    logic [WIDTH-1:0] src_sel;
    logic             run;
    logic             accept;
    logic             sel_legal;
    logic             sel_nz;
    logic             redirect;

    assign run       = (state_q == S_RUN);
    assign accept    = upd.upd_valid && run;
    assign sel_legal = ({1'b0, upd.sel} < NUM_SRC_L);
    assign sel_nz    = (upd.sel != '0);
    assign redirect  = accept && sel_legal && sel_nz;

    // Illegal selectors never match a k, so src_sel is only meaningful when sel_legal.
    always_comb begin
        src_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (upd.sel == SEL_W'(k)) begin
                src_sel = upd.data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        upd.upd_ready = 1'b0;
        pc_valid      = 1'b0;
        case (state_q)
            S_RUN: begin
                upd.upd_ready = 1'b1;
                pc_valid      = 1'b1;
                if (redirect && HAS_FLUSH) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LD;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                // A zero count cannot occur normally; leaving on it keeps the FSM from sticking.
                if (cnt_q <= 4'd1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_VECTOR;
            prev_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            if (sel_legal) begin
                pc_q   <= src_sel;
                prev_q <= pc_q;
            end else begin
                err_q  <= 1'b1;
            end
        end
    end

    assign pc_out  = pc_q;
    assign pc_prev = prev_q;
    assign sel_err = err_q;

`ifdef PC_SOURCE_REDIRECT_COUNT_EN
    logic [31:0] rc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rc_q <= '0;
        end else if (redirect) begin
            rc_q <= rc_q + 32'd1;
        end
    end

    assign redirect_count = rc_q;
`else
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed bench for pc_source_unit: a driver pushes hand-computed post-edge
// expectations into a queue and a monitor pops and compares them after each edge.
module tb_pc_source_unit;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 5;
    localparam int SEL_W   = 3;
`ifdef PC_SOURCE_REDIRECT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] prev;
        logic        valid;
        logic        err;
        logic [31:0] rc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out, pc_prev, redirect_count;
    logic        pc_valid, sel_err;
    logic [31:0] src0, src1, src2, src3, src4;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    pc_source_unit_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    pc_source_unit #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
        .RESET_VECTOR(32'h0000_0000), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .upd(bus.slave),
        .pc_out(pc_out),
        .pc_prev(pc_prev),
        .pc_valid(pc_valid),
        .sel_err(sel_err),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    always_comb bus.data_in = {src4, src3, src2, src1, src0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs before the next edge and queue what must hold after it.
    task automatic step(input logic rst, input logic v, input logic [2:0] s,
                        input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] epc, input logic [31:0] eprev,
                        input logic evalid, input logic eerr, input int nred);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        bus.upd_valid = v;
        bus.sel       = s;
        src0 = s0; src1 = s1; src2 = s2;
        e.pc    = epc;
        e.prev  = eprev;
        e.valid = evalid;
        e.err   = eerr;
        e.rc    = CNT_EN ? 32'(nred) : 32'd0;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc_out",         pc_out,                 e.pc);
                chk("pc_prev",        pc_prev,                e.prev);
                chk("pc_valid",       {31'd0, pc_valid},      {31'd0, e.valid});
                chk("upd_ready",      {31'd0, bus.upd_ready}, {31'd0, e.valid});
                chk("sel_err",        {31'd0, sel_err},       {31'd0, e.err});
                chk("redirect_count", redirect_count,         e.rc);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        reset = 1'b1; bus.upd_valid = 1'b0; bus.sel = '0;
        src0 = 32'h0; src1 = 32'h0; src2 = 32'h0; src3 = 32'h300; src4 = 32'h400;
        //    rst v  sel   src0      src1      src2      pc        prev      vld  err  red
        step(1, 0, 3'd0, 32'h000, 32'h000, 32'h000, 32'h000, 32'h000, 1, 0, 0); // reset
        step(0, 0, 3'd0, 32'h000, 32'h000, 32'h000, 32'h000, 32'h000, 1, 0, 0); // idle after release
        step(0, 1, 3'd0, 32'h004, 32'h000, 32'h000, 32'h004, 32'h000, 1, 0, 0); // seq
        step(0, 1, 3'd0, 32'h008, 32'h000, 32'h000, 32'h008, 32'h004, 1, 0, 0); // seq back-to-back
        step(0, 1, 3'd2, 32'h00c, 32'h000, 32'h100, 32'h100, 32'h008, 0, 0, 1); // redirect
        step(0, 1, 3'd1, 32'h00c, 32'h200, 32'h100, 32'h100, 32'h008, 0, 0, 1); // held in flush
        step(0, 1, 3'd1, 32'h00c, 32'h200, 32'h100, 32'h100, 32'h008, 1, 0, 1); // flush ends
        step(0, 1, 3'd1, 32'h00c, 32'h200, 32'h100, 32'h200, 32'h100, 0, 0, 2); // accepted
        step(0, 0, 3'd0, 32'h00c, 32'h200, 32'h100, 32'h200, 32'h100, 0, 0, 2);
        step(0, 0, 3'd0, 32'h00c, 32'h200, 32'h100, 32'h200, 32'h100, 1, 0, 2);
        step(0, 1, 3'd6, 32'h00c, 32'h200, 32'h100, 32'h200, 32'h100, 1, 1, 2); // illegal
        step(0, 1, 3'd5, 32'h00c, 32'h200, 32'h100, 32'h200, 32'h100, 1, 1, 2); // sel == NUM_SRC
        step(0, 1, 3'd0, 32'h204, 32'h200, 32'h100, 32'h204, 32'h200, 1, 1, 2); // err sticky
        step(0, 1, 3'd4, 32'h204, 32'h200, 32'h100, 32'h400, 32'h204, 0, 1, 3); // top legal src
        step(1, 0, 3'd0, 32'h204, 32'h200, 32'h100, 32'h000, 32'h000, 1, 0, 0); // reset mid-flush
        step(0, 0, 3'd0, 32'h204, 32'h200, 32'h100, 32'h000, 32'h000, 1, 0, 0);
        step(0, 1, 3'd3, 32'h204, 32'h200, 32'h100, 32'h300, 32'h000, 0, 0, 1);
        step(0, 0, 3'd0, 32'h204, 32'h200, 32'h100, 32'h300, 32'h000, 0, 0, 1);
        step(0, 0, 3'd0, 32'h204, 32'h200, 32'h100, 32'h300, 32'h000, 1, 0, 1);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
